seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the combinational execute ALU.
- Executes all base RV32I ALU operations plus the full RV32M multiply/divide set.
- Base ops complete in one cycle. M ops run iteratively in a multi-cycle FSM.
- Sits in the EX stage behind a valid/ready interface; the pipeline stalls on in_ready/out_valid.

Parameters:
- XLEN, 32: operand and result width. Legal values are 32 and 64.
- CNT_W, $clog2(XLEN)+1: width of the iteration counter. Derived; not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of any in-flight operation.
- in_valid  in  1  operands and Op are valid.
- in_ready  out  1  unit can accept a new operation.
- A  in  XLEN  operand 1 (rs1).
- B  in  XLEN  operand 2 (rs2 or immediate).
- Op  in  5  operation select.
  - Op[4]=0: Op[3:0] is the riscv_pkg ALU code (ALU_AND/OR/ADD/SUB/SLT/SLTU/XOR/SLL/SRL/SRA).
  - Op[4]=1: Op[2:0] is the RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- out_valid  out  1  Result and Zero are valid.
- out_ready  in  1  consumer accepts the result.
- Result  out  XLEN  operation result.
- Zero  out  1  high when Result equals 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - in_ready=1, out_valid=0, Result=0, Zero=1, busy=0.
  - Counter and partial registers cleared.
- Accept condition: in_valid & in_ready. in_ready is 1 only in IDLE, so there is one operation in flight at a time.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE, on accept:
  - Base op: result computed combinationally and registered → DONE. out_valid rises the cycle after accept (latency 1).
  - Unknown base code: Result=0.
  - Shift amount: B[$clog2(XLEN)-1:0].
  - MUL*: operands latched; MUL and MULH use signed magnitudes, MULHSU signs A only, MULHU is unsigned → MUL.
  - DIV/REM with B==0: quotient all ones, remainder =A → DONE (latency 1).
  - DIV/REM with A=most-negative and B=-1 (signed): quotient =A, remainder =0 → DONE (latency 1).
  - Other DIV*/REM*: operand magnitudes latched → DIV.
- MUL: shift-add over a 2·XLEN product. One bit per cycle for XLEN cycles, then → FIX.
- DIV: restoring divide, one quotient bit per cycle for XLEN cycles, then → FIX.
- FIX (1 cycle): applies sign correction, then selects the output:
  - MUL: low half. MULH*: high half.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder takes the sign of A.
  - Then → DONE.
- Iterative latency: out_valid rises XLEN+2 cycles after accept (34 for XLEN=32).
- DONE:
  - out_valid=1; Result and Zero held stable until out_ready.
  - out_valid & out_ready → IDLE.
  - No new accept in the same cycle as the handshake. in_ready rises the following cycle.
- Zero is registered together with Result and is valid only while out_valid=1.
- flush in any state:
  - Next state IDLE, out_valid=0, no result emitted.
  - flush has priority over accept and over the out handshake in the same cycle.
- Reset asserted mid-operation: immediate return to the reset values; the partial result is discarded.
- A and B are don't-care after accept; the unit works only from its latched copies.

Optional Feature:
- Macro: SEQ_ALU_FAST_MUL_EN.
- Defined:
  - MUL* ops use a single-cycle 2·XLEN-bit product from the synthesis multiplier and go IDLE→DONE with latency 1.
  - The MUL state is unused.
  - DIV* timing is unchanged.
- Undefined:
  - MUL* use the iterative path with latency XLEN+2.
  - No hardware multiplier is inferred.

Test Plan:
- Base ops, XLEN=32:
  - ADD 7+5 → Result=12, Zero=0, out_valid on cycle 1.
  - SUB 5-5 → Result=0, Zero=1.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLTU 1<0xFFFFFFFF → 1.
- Multiply:
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0. MULHU same operands → 0xFFFFFFFE.
  - MUL 0x10000×0x10000 → 0.
  - out_valid exactly 34 cycles after accept (1 with SEQ_ALU_FAST_MUL_EN).
- Divide:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - Latency 34.
- Boundaries:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/-1 → 0x80000000; REM same → 0.
  - Each boundary case has latency 1.
- Backpressure: hold out_ready=0 for 10 cycles after DIV completes → Result stable, out_valid=1, in_ready=0. Release → in_ready=1 the next cycle.
- Kill and reset:
  - flush at iteration 10 of a MUL → no out_valid, in_ready=1 the next cycle.
  - rst_n low mid-DIV → immediate reset values; a following ADD 1+1 → 2 correct.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: handshaked RV32I/RV32M execute unit; base ops take one cycle, M ops iterate.
// Optional macro SEQ_ALU_FAST_MUL_EN selects a single-cycle multiplier for MUL* ops.
module seq_alu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      Op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] F3_MUL = 3'd0;

  localparam logic [XLEN-1:0]   ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);

`ifdef SEQ_ALU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic [XLEN-1:0] base_op(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b,
                                               input logic [3:0]      code);
    logic [XLEN-1:0] r;
    r = {XLEN{1'b0}};
    case (code)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[SHW-1:0];
      ALU_SRL:  r = a >> b[SHW-1:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[SHW-1:0]);
      default:  r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] mag2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_t              state_r, state_n;
  logic                in_ready_r, busy_r, out_valid_r, zero_r;
  logic [XLEN-1:0]     result_r;
  logic [2*XLEN-1:0]   prod_r;
  logic [XLEN-1:0]     opnd_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [2:0]          op_r;
  logic                qneg_r, rneg_r;

  logic                accept_s, is_mul_s, a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic                div_by0_s, div_ovf_s, div_ok_s;
  logic [XLEN-1:0]     base_res_s, quick_res_s, fast_res_s, fix_res_s, div_diff_s;
  logic [XLEN:0]       mul_sum_s, div_sh_s;
  logic [2*XLEN-1:0]   mul_step_s, div_step_s, fix_prod_s;

  assign accept_s  = in_valid & in_ready_r;
  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign Result    = result_r;
  assign Zero      = zero_r;

  // Operand decode: signedness, magnitude signs, divide special cases and base result.
  always_comb begin
    is_mul_s = Op[4] & ~Op[2];
    if (Op[2]) begin
      a_sgn_s = ~Op[0];
      b_sgn_s = ~Op[0];
    end else begin
      a_sgn_s = (Op[1:0] != 2'b11);
      b_sgn_s = ~Op[1];
    end
    a_neg_s   = a_sgn_s & A[XLEN-1];
    b_neg_s   = b_sgn_s & B[XLEN-1];
    div_by0_s = (B == ZERO);
    div_ovf_s = ~Op[0] & (A == MIN_NEG) & (B == ONES);
    if (div_by0_s) begin
      quick_res_s = Op[1] ? A : ONES;
    end else begin
      quick_res_s = Op[1] ? ZERO : A;
    end
    base_res_s = base_op(A, B, Op[3:0]);
  end

`ifdef SEQ_ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a_s, fast_b_s, fast_p_s;
  assign fast_a_s   = {{XLEN{a_neg_s}}, A};
  assign fast_b_s   = {{XLEN{b_neg_s}}, B};
  assign fast_p_s   = fast_a_s * fast_b_s;
  assign fast_res_s = (Op[2:0] == F3_MUL) ? fast_p_s[XLEN-1:0] : fast_p_s[2*XLEN-1:XLEN];
`else
  assign fast_res_s = {XLEN{1'b0}};
`endif

  // Iteration steps (shift-add multiply, restoring divide) and final sign fix-up.
  always_comb begin
    mul_sum_s  = {1'b0, prod_r[2*XLEN-1:XLEN]} + {1'b0, (prod_r[0] ? opnd_r : ZERO)};
    mul_step_s = {mul_sum_s, prod_r[XLEN-1:1]};

    // Upper half holds the partial remainder, lower half the dividend shifting into quotient.
    div_sh_s   = prod_r[2*XLEN-1:XLEN-1];
    div_ok_s   = (div_sh_s >= {1'b0, opnd_r});
    div_diff_s = div_sh_s[XLEN-1:0] - opnd_r;
    if (div_ok_s) begin
      div_step_s = {div_diff_s, prod_r[XLEN-2:0], 1'b1};
    end else begin
      div_step_s = {prod_r[2*XLEN-2:0], 1'b0};
    end

    fix_prod_s = mag2(prod_r, qneg_r);
    if (op_r[2]) begin
      if (op_r[1]) begin
        fix_res_s = mag(prod_r[2*XLEN-1:XLEN], rneg_r);
      end else begin
        fix_res_s = mag(prod_r[XLEN-1:0], qneg_r);
      end
    end else if (op_r == F3_MUL) begin
      fix_res_s = fix_prod_s[XLEN-1:0];
    end else begin
      fix_res_s = fix_prod_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic; flush overrides accept and the output handshake.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_n = ST_IDLE;
        end else if (!Op[4]) begin
          state_n = ST_DONE;
        end else if (is_mul_s) begin
          state_n = FAST_MUL ? ST_DONE : ST_MUL;
        end else if (div_by0_s || div_ovf_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_DIV;
        end
      end
      ST_MUL:  state_n = (cnt_r == CNT_LAST) ? ST_FIX : ST_MUL;
      ST_DIV:  state_n = (cnt_r == CNT_LAST) ? ST_FIX : ST_DIV;
      ST_FIX:  state_n = ST_DONE;
      ST_DONE: state_n = out_ready ? ST_IDLE : ST_DONE;
      default: state_n = ST_IDLE;
    endcase
    if (flush) begin
      state_n = ST_IDLE;
    end else begin
      state_n = state_n;
    end
  end

  // State register with registered ready/busy decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      in_ready_r <= (state_n == ST_IDLE);
      busy_r     <= (state_n != ST_IDLE);
    end
  end

  // Datapath: operand latching, iteration, result and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r      <= {(2*XLEN){1'b0}};
      opnd_r      <= {XLEN{1'b0}};
      cnt_r       <= CNT_ZERO;
      op_r        <= 3'd0;
      qneg_r      <= 1'b0;
      rneg_r      <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      zero_r      <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      cnt_r       <= CNT_ZERO;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r   <= Op[2:0];
            cnt_r  <= CNT_ZERO;
            qneg_r <= a_neg_s ^ b_neg_s;
            rneg_r <= a_neg_s;
            if (!Op[4]) begin
              result_r    <= base_res_s;
              zero_r      <= (base_res_s == ZERO);
              out_valid_r <= 1'b1;
            end else if (is_mul_s && FAST_MUL) begin
              result_r    <= fast_res_s;
              zero_r      <= (fast_res_s == ZERO);
              out_valid_r <= 1'b1;
            end else if (is_mul_s) begin
              opnd_r <= mag(A, a_neg_s);
              prod_r <= {ZERO, mag(B, b_neg_s)};
            end else if (div_by0_s || div_ovf_s) begin
              result_r    <= quick_res_s;
              zero_r      <= (quick_res_s == ZERO);
              out_valid_r <= 1'b1;
            end else begin
              opnd_r <= mag(B, b_neg_s);
              prod_r <= {ZERO, mag(A, a_neg_s)};
            end
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        ST_MUL: begin
          prod_r <= mul_step_s;
          cnt_r  <= cnt_r + CNT_ONE;
        end
        ST_DIV: begin
          prod_r <= div_step_s;
          cnt_r  <= cnt_r + CNT_ONE;
        end
        ST_FIX: begin
          result_r    <= fix_res_s;
          zero_r      <= (fix_res_s == ZERO);
          out_valid_r <= 1'b1;
        end
        ST_DONE: begin
          out_valid_r <= ~out_ready;
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
